// File: rtl/biriscv_fetch_queue.sv
// Fetch-to-decode instruction queue: trims fetch packets by start offset and
// predicted-taken branches, buffers single instructions, issues up to OUT_PORTS per cycle.
module biriscv_fetch_queue #(
    parameter int FETCH_SLOTS = 2,
    parameter int OUT_PORTS   = 2,
    parameter int DEPTH       = 8,
    parameter int DEPTH_W     = 3
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      branch_request_i,
    input  logic                      fetch_in_valid_i,
    input  logic [32*FETCH_SLOTS-1:0] fetch_in_instr_i,
    input  logic [31:0]               fetch_in_pc_i,
    input  logic [FETCH_SLOTS-1:0]    fetch_in_pred_branch_i,
    input  logic                      fetch_in_fault_fetch_i,
    input  logic                      fetch_in_fault_page_i,
    output logic                      fetch_in_accept_o,
    output logic [OUT_PORTS-1:0]      fetch_out_valid_o,
    output logic [32*OUT_PORTS-1:0]   fetch_out_instr_o,
    output logic [32*OUT_PORTS-1:0]   fetch_out_pc_o,
    output logic [OUT_PORTS-1:0]      fetch_out_fault_fetch_o,
    output logic [OUT_PORTS-1:0]      fetch_out_fault_page_o,
    input  logic [OUT_PORTS-1:0]      fetch_out_accept_i,
    output logic [DEPTH_W:0]          occupancy_o
);

    localparam int SLOT_W = $clog2(FETCH_SLOTS);
    localparam int CNT_W  = DEPTH_W + 1;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        fault_fetch;
        logic        fault_page;
    } entry_t;

    entry_t             mem_q [DEPTH];
    logic [DEPTH_W-1:0] rd_ptr_q;
    logic [DEPTH_W-1:0] rd_ptr_d;
    logic [DEPTH_W-1:0] wr_ptr_q;
    logic [DEPTH_W-1:0] wr_ptr_d;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_d;
    logic [CNT_W-1:0]   push_n;
    logic [CNT_W-1:0]   pop_n;
    logic [SLOT_W-1:0]  start_slot;
    logic [SLOT_W-1:0]  last_slot;
    logic               fault_pkt;
    logic               push;
    logic               pop_run;
    logic [FETCH_SLOTS-1:0] wr_en;
    logic [DEPTH_W-1:0] wr_idx  [FETCH_SLOTS];
    entry_t             wr_data [FETCH_SLOTS];

    // Space is judged on the registered count only; a same-cycle pop never helps.
    assign fetch_in_accept_o = (count_q <= CNT_W'(DEPTH - FETCH_SLOTS));
    assign push       = fetch_in_valid_i & fetch_in_accept_o & ~branch_request_i;
    assign fault_pkt  = fetch_in_fault_fetch_i | fetch_in_fault_page_i;
    assign start_slot = fetch_in_pc_i[SLOT_W+1:2];
    assign occupancy_o = count_q;

    // Lowest predicted-taken slot at or after the start ends the packet.
    always_comb begin
        last_slot = SLOT_W'(FETCH_SLOTS - 1);
        for (int s = FETCH_SLOTS - 1; s >= 0; s--) begin
            if ((SLOT_W'(s) >= start_slot) && fetch_in_pred_branch_i[s]) begin
                last_slot = SLOT_W'(s);
            end
        end
    end

    always_comb begin
        push_n = '0;
        for (int s = 0; s < FETCH_SLOTS; s++) begin
            wr_en[s]   = push && !fault_pkt &&
                         (SLOT_W'(s) >= start_slot) &&
                         (SLOT_W'(s) <= last_slot);
            wr_idx[s]  = wr_ptr_q + DEPTH_W'(s - int'(start_slot));
            wr_data[s] = '{
                instr:       fetch_in_instr_i[32*s +: 32],
                pc:          {fetch_in_pc_i[31:SLOT_W+2], SLOT_W'(s), 2'b00},
                fault_fetch: 1'b0,
                fault_page:  1'b0
            };
            if (wr_en[s]) begin
                push_n = push_n + CNT_W'(1);
            end
        end
        // A faulting packet collapses to one marker entry for decode to trap on.
        if (push && fault_pkt) begin
            wr_en      = '0;
            wr_en[0]   = 1'b1;
            wr_idx[0]  = wr_ptr_q;
            wr_data[0] = '{
                instr:       32'h0,
                pc:          fetch_in_pc_i,
                fault_fetch: fetch_in_fault_fetch_i,
                fault_page:  fetch_in_fault_page_i
            };
            push_n     = CNT_W'(1);
        end
    end

    // Only an unbroken run of accepts from port 0 retires instructions.
    always_comb begin
        pop_n   = '0;
        pop_run = 1'b1;
        for (int k = 0; k < OUT_PORTS; k++) begin
            if (pop_run && (count_q > CNT_W'(k)) && fetch_out_accept_i[k]) begin
                pop_n = pop_n + CNT_W'(1);
            end else begin
                pop_run = 1'b0;
            end
        end
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q + DEPTH_W'(pop_n);
        wr_ptr_d = wr_ptr_q + DEPTH_W'(push_n);
        count_d  = count_q + push_n - pop_n;
        if (branch_request_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: validity comes from count alone.
    always_ff @(posedge clk_i) begin
        for (int s = 0; s < FETCH_SLOTS; s++) begin
            if (wr_en[s]) begin
                mem_q[wr_idx[s]] <= wr_data[s];
            end
        end
    end

    for (genvar k = 0; k < OUT_PORTS; k++) begin : g_out
        logic [DEPTH_W-1:0] idx;
        assign idx = rd_ptr_q + DEPTH_W'(k);
        assign fetch_out_valid_o[k]       = (count_q > CNT_W'(k));
        assign fetch_out_instr_o[32*k +: 32] = mem_q[idx].instr;
        assign fetch_out_pc_o[32*k +: 32]    = mem_q[idx].pc;
        assign fetch_out_fault_fetch_o[k] = mem_q[idx].fault_fetch;
        assign fetch_out_fault_page_o[k]  = mem_q[idx].fault_page;
    end

endmodule

// File: doc/biriscv_fetch_queue.md
Name: biriscv_fetch_queue

Overview:
- Parametrised instruction queue between the fetch unit and decode.
- Generalises the fixed 64-bit, two-slot fetch-to-decode hand-off to FETCH_SLOTS instructions per packet in, OUT_PORTS instructions per cycle out, and DEPTH entries of buffering.
- Trims each packet by its start PC offset and by predicted-taken branches, carries fault flags per instruction, and flushes on branch redirect.

Parameters:
- FETCH_SLOTS, 2, 32-bit instruction slots per fetch packet; power of two, ≥2.
- OUT_PORTS, 2, instruction output ports to decode; 1..DEPTH.
- DEPTH, 8, queue entries (one instruction each); power of two, ≥ FETCH_SLOTS.
- DEPTH_W, 3, log2(DEPTH).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- branch_request_i  in  1  redirect/flush.
- fetch_in_valid_i  in  1  packet valid.
- fetch_in_instr_i  in  32*FETCH_SLOTS  packet; slot s at bits [32s+31:32s].
- fetch_in_pc_i  in  32  PC of first wanted instruction. Bits [log2(FETCH_SLOTS)+1:2] give the start slot.
- fetch_in_pred_branch_i  in  FETCH_SLOTS  slot predicted taken.
- fetch_in_fault_fetch_i  in  1  bus error on packet.
- fetch_in_fault_page_i  in  1  page fault on packet.
- fetch_in_accept_o  out  1  packet accepted when valid.
- fetch_out_valid_o  out  OUT_PORTS  per-port valid.
- fetch_out_instr_o  out  32*OUT_PORTS  per-port instruction.
- fetch_out_pc_o  out  32*OUT_PORTS  per-port PC.
- fetch_out_fault_fetch_o  out  OUT_PORTS  per-port fetch fault.
- fetch_out_fault_page_o  out  OUT_PORTS  per-port page fault.
- fetch_out_accept_i  in  OUT_PORTS  per-port consume.
- occupancy_o  out  DEPTH_W+1  current entry count.

Behaviour:
- Storage: circular buffer; entry = {instr[31:0], pc[31:0], fault_fetch, fault_page}; rd_ptr/wr_ptr DEPTH_W bits wrap mod DEPTH; count DEPTH_W+1 bits.
- Reset (async, rst_ni low): rd_ptr=wr_ptr=0, count=0. Consequently fetch_out_valid_o=0, occupancy_o=0, fetch_in_accept_o=1. Reset mid-operation discards all contents immediately.
- fetch_in_accept_o = (DEPTH - count) ≥ FETCH_SLOTS, evaluated on registered count only. A same-cycle pop does not raise it.
- Push (fetch_in_valid_i & accept & !branch_request_i):
  - start = pc[log2(FETCH_SLOTS)+1:2].
  - last = lowest slot ≥ start with pred_branch set, else FETCH_SLOTS-1.
  - Enqueue slots start..last in order; slot s gets pc = {pc[31:log2(FETCH_SLOTS)+2], s[..], 2'b00}.
  - Pred_branch bits below start are ignored.
  - Fault packet (either fault flag): enqueue exactly one entry, instr=0, pc=fetch_in_pc_i, flags copied.
- Outputs: port k shows entry rd_ptr+k; valid_k = (count > k). Data is undefined when valid is low.
- Pop: n = number of leading ports k (from 0) with valid_k & accept_k. An accept on port k with port k-1 not accepted is ignored. rd_ptr += n.
- Push and pop in the same cycle: count_next = count + pushed - n.
- Latency: entry pushed in cycle N is visible on outputs in cycle N+1. No combinational in-to-out path.
- Flush (branch_request_i=1): next cycle rd_ptr=wr_ptr=0, count=0. The same-cycle pop and any same-cycle input packet are discarded. Outputs are not gated combinationally during the flush cycle; the consumer drops them itself.
- Full: count=DEPTH gives accept=0. Ports still drain.
- Empty: all valid=0; accept has no effect.
- Wrap: multi-entry pushes and pops straddling DEPTH-1→0 must keep order.

Test Plan:
- Basic push: FETCH_SLOTS=2. Packet pc=0x1000, instr={0xBBBB0013, 0xAAAA0013}, no pred. Expect next cycle out0=0xAAAA0013@0x1000, out1=0xBBBB0013@0x1004, occupancy_o=2.
- Offset start: pc=0x2004 → one entry, slot1 instr @0x2004, occupancy_o=1. Pred-taken: pc=0x3000, pred_branch=2'b01 → only slot0 enqueued.
- Fault: fault_page=1, pc=0x4004 → single entry, instr=0, pc=0x4004, fault_page=1. Out1 stays invalid.
- Partial accept: 3 entries; accept=2'b10 → no pop. accept=2'b01 → pop 1, occupancy_o 3→2.
- Full and wrap: DEPTH=8, no pops, push 4 packets. After 4th, accept=0 and occupancy_o=8. Pop 2/cycle while pushing; verify PC order across the 7→0 boundary for 20 packets.
- Flush: occupancy_o=5, branch_request_i with valid packet and accept=2'b11 same cycle → next cycle occupancy_o=0, all valid=0, packet not stored. Async rst_ni low mid-stream → immediately occupancy_o=0, accept=1.
